// File: rtl/keyb_pkg.sv
// rtl/keyb_pkg.sv - shared constants and helpers for the 4x4 keypad scanner
package keyb_pkg;

  localparam int KEYB_ROWS  = 4;
  localparam int KEYB_COLS  = 4;
  localparam int KEY_CODE_W = 4;

  // Scanner FSM encoding
  localparam logic [1:0] ST_DRIVE  = 2'd0;
  localparam logic [1:0] ST_SAMPLE = 2'd1;
  localparam logic [1:0] ST_HOLD   = 2'd2;

  // Active-low strobe pattern with only the selected column pulled low
  function automatic logic [KEYB_COLS-1:0] col_onecold(input logic [1:0] col);
    return ~(KEYB_COLS'(1) << col);
  endfunction

endpackage

// File: rtl/keyb_row_sync.sv
// rtl/keyb_row_sync.sv - two-flop synchronizer for the keypad row inputs
module keyb_row_sync
  import keyb_pkg::*;
(
  input  logic                 clk_i,
  input  logic                 reset_i,
  input  logic [KEYB_ROWS-1:0] d_i,
  output logic [KEYB_ROWS-1:0] q_o
);

  logic [KEYB_ROWS-1:0] meta_q;
  logic [KEYB_ROWS-1:0] sync_q;

  // Two-stage resync; resets to all-released so no phantom press follows reset
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      meta_q <= '1;
      sync_q <= '1;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/keyb_scanner.sv
// rtl/keyb_scanner.sv - 4x4 keypad column scanner; KEYB_SCANNER_SYNC_EN adds row resync
module keyb_scanner
  import keyb_pkg::*;
#(
  parameter int SETTLE_CYCLES = 50000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [KEYB_ROWS-1:0]  rows_in,
  output logic [KEYB_COLS-1:0]  cols_out,
  output logic                  btn_press,
  output logic [1:0]            key_row,
  output logic [1:0]            key_col,
  output logic [KEY_CODE_W-1:0] key_code
);

  localparam int              CNT_W    = $clog2(SETTLE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(SETTLE_CYCLES - 1);

  logic [KEYB_ROWS-1:0]  rows_s;
  logic [1:0]            state_q, state_d;
  logic [1:0]            col_q, col_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [KEYB_COLS-1:0]  cols_q, cols_d;
  logic                  btn_q, btn_d;
  logic [1:0]            krow_q, krow_d;
  logic [1:0]            kcol_q, kcol_d;
  logic [KEY_CODE_W-1:0] kcode_q, kcode_d;
  logic [1:0]            hit_row;
  logic                  any_low;

`ifdef KEYB_SCANNER_SYNC_EN
  keyb_row_sync u_row_sync (
    .clk_i   (clk),
    .reset_i (reset),
    .d_i     (rows_in),
    .q_o     (rows_s)
  );
`else
  assign rows_s = rows_in;
`endif

  // Lowest-numbered closed row wins when several rows read low together
  function automatic logic [1:0] lowest_low(input logic [KEYB_ROWS-1:0] rows);
    logic [1:0] r;
    r = 2'd0;
    for (int i = KEYB_ROWS - 1; i >= 0; i--) begin
      if (!rows[i]) r = 2'(i);
    end
    return r;
  endfunction

  assign hit_row = lowest_low(rows_s);
  assign any_low = ~&rows_s;

  // Scan sequencing: settle a column, sample once, freeze while the key stays down
  always_comb begin
    state_d = state_q;
    col_d   = col_q;
    cnt_d   = cnt_q;
    btn_d   = btn_q;
    krow_d  = krow_q;
    kcol_d  = kcol_q;
    kcode_d = kcode_q;
    case (state_q)
      ST_DRIVE: begin
        if (cnt_q == '0) state_d = ST_SAMPLE;
        else             cnt_d   = cnt_q - CNT_W'(1);
      end
      ST_SAMPLE: begin
        if (any_low) begin
          krow_d  = hit_row;
          kcol_d  = col_q;
          kcode_d = {hit_row, col_q};
          btn_d   = 1'b1;
          state_d = ST_HOLD;
        end else begin
          col_d   = col_q + 2'd1;
          cnt_d   = CNT_LOAD;
          state_d = ST_DRIVE;
        end
      end
      ST_HOLD: begin
        // Only the latched row matters; a bounce that reads high ends the hold
        if (rows_s[krow_q]) begin
          btn_d   = 1'b0;
          col_d   = col_q + 2'd1;
          cnt_d   = CNT_LOAD;
          state_d = ST_DRIVE;
        end
      end
      default: begin
        cnt_d   = CNT_LOAD;
        state_d = ST_DRIVE;
      end
    endcase
    cols_d = col_onecold(col_d);
  end

  // State and registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_DRIVE;
      col_q   <= 2'd0;
      cnt_q   <= CNT_LOAD;
      cols_q  <= 4'b1110;
      btn_q   <= 1'b0;
      krow_q  <= 2'd0;
      kcol_q  <= 2'd0;
      kcode_q <= '0;
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      cnt_q   <= cnt_d;
      cols_q  <= cols_d;
      btn_q   <= btn_d;
      krow_q  <= krow_d;
      kcol_q  <= kcol_d;
      kcode_q <= kcode_d;
    end
  end

  assign cols_out  = cols_q;
  assign btn_press = btn_q;
  assign key_row   = krow_q;
  assign key_col   = kcol_q;
  assign key_code  = kcode_q;

endmodule

// File: tb/tb_keyb_scanner.sv
// tb/tb_keyb_scanner.sv - self-checking bench for keyb_scanner with an emulated key matrix
module tb_keyb_scanner;

  localparam int S = 4;
`ifdef KEYB_SCANNER_SYNC_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 0;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] rows_in;
  logic [3:0] cols_out;
  logic       btn_press;
  logic [1:0] key_row;
  logic [1:0] key_col;
  logic [3:0] key_code;

  // keys[r*4+c] = 1 means the key at row r, column c is held down
  logic [15:0] keys = '0;

  int tests = 0;
  int fails = 0;

  // Reference model: scan timeline position and latched key
  int         m_col, m_pos, m_krow, m_kcol;
  bit         m_hold, m_btn;
  logic [3:0] m_hist0, m_hist1;

  keyb_scanner #(.SETTLE_CYCLES(S)) dut (
    .clk       (clk),
    .reset     (reset),
    .rows_in   (rows_in),
    .cols_out  (cols_out),
    .btn_press (btn_press),
    .key_row   (key_row),
    .key_col   (key_col),
    .key_code  (key_code)
  );

  always #5 clk = ~clk;

  // Passive keypad: a row reads low when a held key sits on a driven column
  always_comb begin
    rows_in = 4'b1111;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        if (keys[r*4+c] && (cols_out[c] == 1'b0)) rows_in[r] = 1'b0;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_edge(input logic [3:0] rv, input logic rs);
    logic [3:0] r;
    if (rs) begin
      m_col = 0; m_pos = 0; m_hold = 0; m_btn = 0; m_krow = 0; m_kcol = 0;
      m_hist0 = 4'hF; m_hist1 = 4'hF;
    end else begin
      r = (LAT == 2) ? m_hist1 : rv;
      m_hist1 = m_hist0;
      m_hist0 = rv;
      if (m_hold) begin
        if (r[m_krow]) begin
          m_hold = 0; m_btn = 0; m_col = (m_col + 1) % 4; m_pos = 0;
        end
      end else if (m_pos == S) begin
        if (r != 4'hF) begin
          m_krow = 0;
          while (r[m_krow]) m_krow++;
          m_kcol = m_col; m_hold = 1; m_btn = 1;
        end else begin
          m_col = (m_col + 1) % 4; m_pos = 0;
        end
      end else begin
        m_pos++;
      end
    end
  endtask

  task automatic step();
    logic [3:0] rv;
    logic       rs;
    logic [3:0] ec;
    #2;
    rv = rows_in;
    rs = reset;
    @(posedge clk);
    model_edge(rv, rs);
    #1;
    ec = 4'b1111;
    ec[m_col] = 1'b0;
    check("cols_out", 32'(cols_out), 32'(ec));
    check("btn_press", 32'(btn_press), 32'(m_btn));
    check("key_row", 32'(key_row), m_krow);
    check("key_col", 32'(key_col), m_kcol);
    check("key_code", 32'(key_code), m_krow * 4 + m_kcol);
  endtask

  task automatic wait_btn(input logic target, input int budget, output int n);
    n = 0;
    while (btn_press !== target && n < budget) begin
      step();
      n++;
    end
    check("wait_btn", 32'(btn_press), 32'(target));
  endtask

  initial begin
    int n;
    int idx;

    // Reset state
    reset = 1'b1;
    step();
    step();
    check("rst_cols", 32'(cols_out), 32'hE);
    check("rst_btn", 32'(btn_press), 32'h0);
    check("rst_code", 32'(key_code), 32'h0);

    // Idle scan across all four columns and the wrap back to column 0
    reset = 1'b0;
    for (int i = 0; i < 22; i++) step();
    check("idle_btn", 32'(btn_press), 32'h0);

    // Press row 2 on column 1
    keys[2*4+1] = 1'b1;
    wait_btn(1'b1, 60, n);
    check("press_row", 32'(key_row), 32'h2);
    check("press_col", 32'(key_col), 32'h1);
    check("press_code", 32'(key_code), 32'h9);
    check("press_cols", 32'(cols_out), 32'hD);
    for (int i = 0; i < 5; i++) step();
    check("held_cols", 32'(cols_out), 32'hD);

    // Release: btn_press falls and scanning resumes on column 2
    keys[2*4+1] = 1'b0;
    wait_btn(1'b0, 10, n);
    check("release_lat", n, 1 + LAT);
    check("release_cols", 32'(cols_out), 32'hB);
    check("release_code", 32'(key_code), 32'h9);

    // Rows 1 and 3 both closed on column 3: lowest row wins
    keys[1*4+3] = 1'b1;
    keys[3*4+3] = 1'b1;
    wait_btn(1'b1, 60, n);
    check("multi_row", 32'(key_row), 32'h1);
    check("multi_code", 32'(key_code), 32'h7);
    keys[3*4+3] = 1'b0;
    for (int i = 0; i < 6; i++) step();
    check("other_row_ignored", 32'(btn_press), 32'h1);

    // Reset while holding
    reset = 1'b1;
    step();
    check("midhold_btn", 32'(btn_press), 32'h0);
    check("midhold_code", 32'(key_code), 32'h0);
    check("midhold_cols", 32'(cols_out), 32'hE);
    reset = 1'b0;
    keys = '0;
    for (int i = 0; i < 4; i++) step();
    check("resettle_cols", 32'(cols_out), 32'hE);
    step();
    check("resettle_next", 32'(cols_out), 32'hD);

    // Random key activity with occasional resets
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 24) == 0) begin
        idx = int'($urandom_range(0, 15));
        keys[idx] = ~keys[idx];
      end
      if ($countones(keys) > 2) keys = '0;
      reset = ($urandom_range(0, 399) == 0);
      step();
    end
    reset = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
